// File: rtl/lsu_pkg.sv
// Shared types, address map and access helpers for the lsu_pio load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } size_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      RG_NONE = 2'b00,
      RG_DMEM = 2'b01,
      RG_OUT  = 2'b10,
      RG_SW   = 2'b11
   } region_e;

   localparam logic [11:0] DMEM_BASE  = 12'h000;
   localparam logic [11:0] OUT_BASE   = 12'h800;
   localparam logic [11:0] OUT_STRIDE = 12'h010;
   localparam logic [11:0] SW_ADDR    = 12'h900;

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] base;
      case (size)
         SZ_B:    base = 4'b0001;
         SZ_H:    base = 4'b0011;
         default: base = 4'b1111;
      endcase
      return base << off;
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_B:    return 1'b0;
         SZ_H:    return off[0];
         SZ_W:    return off != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   // word is already shifted so the accessed bytes sit at the bottom
   function automatic logic [31:0] extend_ld(input logic [31:0] word, input logic [1:0] size,
                                             input logic uns);
      case (size)
         SZ_B:    return {{24{~uns & word[7]}}, word[7:0]};
         SZ_H:    return {{16{~uns & word[15]}}, word[15:0]};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/lsu_pio_if.sv
// Request/response bus between the core memory stage and lsu_pio.
interface lsu_pio_if;
   logic        req_i;
   logic        we_i;
   logic [11:0] addr_i;
   logic [1:0]  size_i;
   logic        unsigned_i;
   logic [31:0] st_data_i;
   logic        ready_o;
   logic        valid_o;
   logic        err_o;
   logic [31:0] ld_data_o;

   modport master (
      output req_i, we_i, addr_i, size_i, unsigned_i, st_data_i,
      input  ready_o, valid_o, err_o, ld_data_o
   );

   modport slave (
      input  req_i, we_i, addr_i, size_i, unsigned_i, st_data_i,
      output ready_o, valid_o, err_o, ld_data_o
   );
endinterface

// File: rtl/lsu_dmem.sv
// Single-port data RAM with per-byte write enable and registered read; contents are not reset.
module lsu_dmem #(
   parameter int WORDS = 512,
   parameter int AW    = 9
) (
   input  logic          clk_i,
   input  logic          en_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);
   logic [31:0] r_mem [WORDS];
   logic [31:0] r_rdata;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            for (int b = 0; b < 4; b++) begin
               if (be_i[b]) r_mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
         r_rdata <= r_mem[addr_i];
      end
   end

   assign rdata_o = r_rdata;
endmodule

// File: rtl/lsu_pio.sv
// Two-state load/store unit with data RAM, memory-mapped output registers and a switch port.
// Define LSU_SW_SYNC_EN to pass io_sw_i through a two-flop synchronizer before capture.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | ready for a request; accept edge writes/reads
// ST_RESP | valid_o pulse with err_o / ld_data_o
module lsu_pio
   import lsu_pkg::*;
#(
   parameter int DMEM_WORDS = 512,
   parameter int N_OUT      = 11
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   lsu_pio_if.slave             bus,
   input  logic [31:0]          io_sw_i,
   output logic [32*N_OUT-1:0]  io_out_o
);
   localparam int          AW         = $clog2(DMEM_WORDS);
   localparam logic [12:0] DMEM_LIMIT = 13'(4 * DMEM_WORDS);
   localparam logic [4:0]  N_OUT_W    = 5'(N_OUT);

   state_e      r_state, w_state_nxt;
   logic        w_accept, w_ready, w_valid;
   logic [1:0]  w_off;
   logic        w_bad, w_dmem_hit, w_out_hit, w_sw_hit, w_do_write;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   region_e     w_region;

   logic        r_we, r_uns, r_bad;
   logic [1:0]  r_size, r_off;
   region_e     r_region;
   logic [3:0]  r_k;
   logic [31:0] r_sw_cap;

   logic [31:0] r_out [N_OUT];
   logic [31:0] w_out_pad [16];
   logic [31:0] w_dmem_rdata, w_sw_src, w_rd_word, w_ld;

   assign w_accept = rst_ni & bus.req_i & (r_state == ST_IDLE);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // valid is gated by reset so a reset landing in RESP never shows a pulse
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_valid     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ready = 1'b1;
            if (w_accept) w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            w_valid     = rst_ni;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_off      = bus.addr_i[1:0];
   assign w_bad      = misaligned(bus.size_i, w_off);
   assign w_be       = byte_en(bus.size_i, w_off);
   assign w_wdata    = bus.st_data_i << {w_off, 3'b000};
   assign w_dmem_hit = {1'b0, bus.addr_i} < DMEM_LIMIT;
   assign w_out_hit  = (bus.addr_i[11:8] == OUT_BASE[11:8]) && ({1'b0, bus.addr_i[7:4]} < N_OUT_W);
   assign w_sw_hit   = bus.addr_i[11:2] == SW_ADDR[11:2];
   assign w_do_write = w_accept & bus.we_i & ~w_bad;

   always_comb begin
      w_region = RG_NONE;
      if (w_dmem_hit)     w_region = RG_DMEM;
      else if (w_out_hit) w_region = RG_OUT;
      else if (w_sw_hit)  w_region = RG_SW;
   end

   lsu_dmem #(
      .WORDS (DMEM_WORDS),
      .AW    (AW)
   ) u_dmem (
      .clk_i   (clk_i),
      .en_i    (w_accept),
      .we_i    (w_do_write & (w_region == RG_DMEM)),
      .be_i    (w_be),
      .addr_i  (bus.addr_i[AW+1:2]),
      .wdata_i (w_wdata),
      .rdata_o (w_dmem_rdata)
   );

`ifdef LSU_SW_SYNC_EN
   logic [31:0] r_sw_s1, r_sw_s2;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_sw_s1 <= '0;
         r_sw_s2 <= '0;
      end else begin
         r_sw_s1 <= io_sw_i;
         r_sw_s2 <= r_sw_s1;
      end
   end

   assign w_sw_src = r_sw_s2;
`else
   assign w_sw_src = io_sw_i;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_we     <= 1'b0;
         r_uns    <= 1'b0;
         r_bad    <= 1'b0;
         r_size   <= 2'b00;
         r_off    <= 2'b00;
         r_region <= RG_NONE;
         r_k      <= 4'd0;
         r_sw_cap <= '0;
      end else if (w_accept) begin
         r_we     <= bus.we_i;
         r_uns    <= bus.unsigned_i;
         r_bad    <= w_bad;
         r_size   <= bus.size_i;
         r_off    <= w_off;
         r_region <= w_region;
         r_k      <= bus.addr_i[7:4];
         r_sw_cap <= w_sw_src;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int k = 0; k < N_OUT; k++) r_out[k] <= '0;
      end else if (w_do_write && (w_region == RG_OUT)) begin
         for (int k = 0; k < N_OUT; k++) begin
            if (bus.addr_i[7:4] == 4'(k)) begin
               for (int b = 0; b < 4; b++) begin
                  if (w_be[b]) r_out[k][8*b +: 8] <= w_wdata[8*b +: 8];
               end
            end
         end
      end
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_out
      assign io_out_o[32*k +: 32] = r_out[k];
   end

   // padded to 16 so the 4-bit register index never leaves the array
   always_comb begin
      for (int i = 0; i < 16; i++) w_out_pad[i] = '0;
      for (int k = 0; k < N_OUT; k++) w_out_pad[k] = r_out[k];
   end

   always_comb begin
      w_rd_word = '0;
      case (r_region)
         RG_DMEM: w_rd_word = w_dmem_rdata;
         RG_OUT:  w_rd_word = w_out_pad[r_k];
         RG_SW:   w_rd_word = r_sw_cap;
         default: w_rd_word = '0;
      endcase
   end

   assign w_ld = extend_ld(w_rd_word >> {r_off, 3'b000}, r_size, r_uns);

   assign bus.ready_o   = w_ready;
   assign bus.valid_o   = w_valid;
   assign bus.err_o     = w_valid & r_bad;
   assign bus.ld_data_o = (w_valid & ~r_we & ~r_bad) ? w_ld : 32'd0;
endmodule

// File: tb/tb_lsu_pio.sv
// Self-checking bench for lsu_pio against a byte-addressed reference model of the address map.
module tb_lsu_pio;
   localparam int DMEM_WORDS = 512;
   localparam int N_OUT      = 11;
   localparam int W          = 32 * N_OUT;

   logic          clk;
   logic          rst_n;
   logic [31:0]   io_sw;
   logic [W-1:0]  io_out;

   int checks   = 0;
   int failures = 0;

   lsu_pio_if bus ();

   lsu_pio #(
      .DMEM_WORDS (DMEM_WORDS),
      .N_OUT      (N_OUT)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .bus      (bus),
      .io_sw_i  (io_sw),
      .io_out_o (io_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: byte view of the map
   logic [7:0]  m_mem [4*DMEM_WORDS];
   logic [31:0] m_out [N_OUT];
   logic [31:0] m_sw;

   // results of the last run_op
   logic          g_err, g_tok, e_err;
   logic [31:0]   g_ld, e_ld;
   logic [W-1:0]  g_out, e_out;

   function automatic logic [7:0] rd_byte(input int a);
      if (a < 4*DMEM_WORDS) return m_mem[a];
      if (a >= 'h800 && a < 'h800 + 16*N_OUT) return m_out[(a - 'h800) / 16][8*(a % 4) +: 8];
      if (a >= 'h900 && a <= 'h903) return m_sw[8*(a % 4) +: 8];
      return 8'h00;
   endfunction

   task automatic wr_byte(input int a, input logic [7:0] v);
      if (a < 4*DMEM_WORDS) m_mem[a] = v;
      else if (a >= 'h800 && a < 'h800 + 16*N_OUT) m_out[(a - 'h800) / 16][8*(a % 4) +: 8] = v;
   endtask

   function automatic logic [W-1:0] exp_outs();
      logic [W-1:0] v;
      for (int k = 0; k < N_OUT; k++) v[32*k +: 32] = m_out[k];
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N_OUT; k++) m_out[k] = '0;
   endtask

   task automatic model_access(input logic we, input logic [11:0] addr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] d,
                               output logic err, output logic [31:0] ld);
      int a, n;
      logic [31:0] v, mask;
      a  = int'(addr);
      n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      ld = '0;
      err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
      if (err) return;
      if (we) begin
         for (int i = 0; i < n; i++) wr_byte(a + i, d[8*i +: 8]);
      end else begin
         v = '0;
         for (int i = 0; i < n; i++) v[8*i +: 8] = rd_byte(a + i);
         if (n < 4) begin
            mask = (32'd1 << (8*n)) - 32'd1;
            if (!uns && v[8*n-1]) v = v | ~mask;
         end
         ld = v;
      end
   endtask

   // one access from IDLE; tok records the ready/valid timing around the accept edge
   task automatic do_req(input logic we, input logic [11:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] d);
      @(negedge clk);
      bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = a; bus.size_i = sz;
      bus.unsigned_i = uns; bus.st_data_i = d;
      g_tok = (bus.ready_o === 1'b1) && (bus.valid_o === 1'b0);
      @(posedge clk); #1;
      bus.req_i = 1'b0;
      g_tok = g_tok && (bus.valid_o === 1'b1) && (bus.ready_o === 1'b0);
      g_err = bus.err_o;
      g_ld  = bus.ld_data_o;
      g_out = io_out;
      @(posedge clk); #1;
      g_tok = g_tok && (bus.valid_o === 1'b0) && (bus.ready_o === 1'b1);
   endtask

   task automatic run_op(input logic we, input logic [11:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] d);
      do_req(we, a, sz, uns, d);
      model_access(we, a, sz, uns, d, e_err, e_ld);
      e_out = exp_outs();
   endtask

   task automatic gen_op(output logic we, output logic [11:0] a, output logic [1:0] sz,
                         output logic uns, output logic [31:0] d);
      case ($urandom_range(0, 3))
         0, 3:    a = 12'h700 + 12'($urandom_range(0, 63));
         1:       a = 12'h800 + 12'($urandom_range(0, 255));
         default: a = 12'h900 + 12'($urandom_range(0, 15));
      endcase
      we  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      d   = $urandom;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ready_o); end
      checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
      checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err_o); end
      checks++; if (bus.ld_data_o !== 32'd0) begin failures++; $display("FAIL reset_ld got=%h exp=0", bus.ld_data_o); end
      checks++; if (io_out !== '0) begin failures++; $display("FAIL reset_io_out got=%h exp=0", io_out); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_dmem();
      run_op(1'b1, 12'h750, 2'd2, 1'b0, 32'h0);
      run_op(1'b1, 12'h752, 2'd2, 1'b0, 32'h13579BDF);
      checks++; if (g_err !== 1'b1 || e_err !== 1'b1) begin failures++; $display("FAIL dmem_mis_err got=%b exp=1", g_err); end
      run_op(1'b0, 12'h750, 2'd2, 1'b0, 32'h0);
      checks++; if (g_ld !== 32'h0) begin failures++; $display("FAIL dmem_mis_nowrite got=%h exp=0", g_ld); end
      run_op(1'b1, 12'h750, 2'd2, 1'b0, 32'h13579BDF);
      checks++; if (g_err !== 1'b0) begin failures++; $display("FAIL dmem_st_err got=%b exp=0", g_err); end
      run_op(1'b0, 12'h750, 2'd2, 1'b0, 32'h0);
      checks++; if (g_ld !== 32'h13579BDF) begin failures++; $display("FAIL dmem_ld_word got=%h exp=13579bdf", g_ld); end
      checks++; if (g_tok !== 1'b1) begin failures++; $display("FAIL dmem_latency got=%b exp=1", g_tok); end
      run_op(1'b1, 12'h751, 2'd0, 1'b0, 32'h000000EF);
      run_op(1'b0, 12'h751, 2'd0, 1'b0, 32'h0);
      checks++; if (g_ld !== 32'hFFFFFFEF) begin failures++; $display("FAIL dmem_ld_byte_s got=%h exp=ffffffef", g_ld); end
      run_op(1'b0, 12'h751, 2'd0, 1'b1, 32'h0);
      checks++; if (g_ld !== 32'h000000EF) begin failures++; $display("FAIL dmem_ld_byte_u got=%h exp=000000ef", g_ld); end
      run_op(1'b0, 12'h750, 2'd2, 1'b0, 32'h0);
      checks++; if (g_ld !== 32'h1357EFDF || g_ld !== e_ld) begin failures++; $display("FAIL dmem_ld_merged got=%h exp=1357efdf", g_ld); end
      run_op(1'b0, 12'h752, 2'd1, 1'b0, 32'h0);
      checks++; if (g_ld !== 32'h00001357) begin failures++; $display("FAIL dmem_ld_half got=%h exp=00001357", g_ld); end
   endtask

   task automatic test_out_regs();
      pulse_reset();
      for (int k = 0; k < N_OUT; k++) begin
         run_op(1'b1, 12'(12'h800 + 16*k), 2'd2, 1'b0, 32'h01234567);
         checks++; if (g_out !== e_out) begin failures++; $display("FAIL out_store_%0d got=%h exp=%h", k, g_out, e_out); end
      end
      for (int k = 0; k < N_OUT; k++) begin
         run_op(1'b0, 12'(12'h800 + 16*k), 2'd2, 1'b0, 32'h0);
         checks++; if (g_ld !== 32'h01234567) begin failures++; $display("FAIL out_load_%0d got=%h exp=01234567", k, g_ld); end
      end
   endtask

   task automatic test_half_out();
      run_op(1'b1, 12'h812, 2'd1, 1'b0, 32'h0000BEEF);
      checks++; if (g_out[63:32] !== 32'hBEEF4567) begin failures++; $display("FAIL half_out got=%h exp=beef4567", g_out[63:32]); end
      checks++; if (g_out !== e_out) begin failures++; $display("FAIL half_out_all got=%h exp=%h", g_out, e_out); end
      run_op(1'b1, 12'h813, 2'd1, 1'b0, 32'h00001111);
      checks++; if (g_err !== 1'b1) begin failures++; $display("FAIL half_mis_err got=%b exp=1", g_err); end
      checks++; if (g_out[63:32] !== 32'hBEEF4567) begin failures++; $display("FAIL half_mis_keep got=%h exp=beef4567", g_out[63:32]); end
   endtask

   task automatic test_switch();
      @(negedge clk);
      io_sw = 32'h5;
      m_sw  = 32'h5;
      repeat (3) @(posedge clk);
      run_op(1'b0, 12'h900, 2'd2, 1'b0, 32'h0);
      checks++; if (g_ld !== 32'h5) begin failures++; $display("FAIL sw_load got=%h exp=5", g_ld); end
      run_op(1'b0, 12'h912, 2'd1, 1'b0, 32'h0);
      checks++; if (g_ld !== 32'h0 || g_err !== 1'b0) begin failures++; $display("FAIL sw_unmapped got=%h/%b exp=0/0", g_ld, g_err); end
      run_op(1'b1, 12'h900, 2'd2, 1'b0, 32'hFFFFFFFF);
      checks++; if (g_err !== 1'b0 || g_out !== e_out) begin failures++; $display("FAIL sw_store_err got=%b exp=0", g_err); end
      run_op(1'b0, 12'h900, 2'd2, 1'b0, 32'h0);
      checks++; if (g_ld !== 32'h5) begin failures++; $display("FAIL sw_store_drop got=%h exp=5", g_ld); end
      @(negedge clk);
      io_sw = 32'h80F0_0000;
      m_sw  = 32'h80F0_0000;
      repeat (3) @(posedge clk);
      run_op(1'b0, 12'h902, 2'd1, 1'b0, 32'h0);
      checks++; if (g_ld !== 32'hFFFF80F0) begin failures++; $display("FAIL sw_half_s got=%h exp=ffff80f0", g_ld); end
   endtask

   task automatic test_illegal();
      run_op(1'b1, 12'h754, 2'd2, 1'b0, 32'hA5A5A5A5);
      run_op(1'b1, 12'h754, 2'd3, 1'b0, 32'h12345678);
      checks++; if (g_err !== 1'b1) begin failures++; $display("FAIL ill_store_err got=%b exp=1", g_err); end
      run_op(1'b0, 12'h754, 2'd3, 1'b0, 32'h0);
      checks++; if (g_err !== 1'b1 || g_ld !== 32'h0) begin failures++; $display("FAIL ill_load got=%b/%h exp=1/0", g_err, g_ld); end
      run_op(1'b0, 12'h754, 2'd2, 1'b0, 32'h0);
      checks++; if (g_ld !== 32'hA5A5A5A5) begin failures++; $display("FAIL ill_nowrite got=%h exp=a5a5a5a5", g_ld); end
   endtask

   task automatic test_random();
      logic we, uns;
      logic [11:0] a;
      logic [1:0] sz;
      logic [31:0] d;
      for (int i = 0; i < 16; i++) run_op(1'b1, 12'(12'h700 + 4*i), 2'd2, 1'b0, $urandom);
      @(negedge clk);
      io_sw = $urandom;
      m_sw  = io_sw;
      repeat (3) @(posedge clk);
      for (int i = 0; i < 80; i++) begin
         gen_op(we, a, sz, uns, d);
         run_op(we, a, sz, uns, d);
         checks++;
         if (g_err !== e_err || g_ld !== e_ld || g_out !== e_out || g_tok !== 1'b1) begin
            failures++;
            $display("FAIL rand_%0d we=%b a=%h sz=%0d u=%b got=%b/%h exp=%b/%h tok=%b", i, we, a, sz,
                     uns, g_err, g_ld, e_err, e_ld, g_tok);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic we, uns, x_err;
      logic [11:0] a;
      logic [1:0] sz;
      logic [31:0] d, x_ld;
      @(negedge clk);
      gen_op(we, a, sz, uns, d);
      bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = a; bus.size_i = sz;
      bus.unsigned_i = uns; bus.st_data_i = d;
      model_access(we, a, sz, uns, d, x_err, x_ld);
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (c % 2 == 0) begin
            checks++;
            if (bus.valid_o !== 1'b1 || bus.err_o !== x_err || bus.ld_data_o !== x_ld) begin
               failures++;
               $display("FAIL b2b_resp_%0d got=%b/%b/%h exp=1/%b/%h", c, bus.valid_o, bus.err_o,
                        bus.ld_data_o, x_err, x_ld);
            end
            if (c < 10) begin
               gen_op(we, a, sz, uns, d);
               bus.we_i = we; bus.addr_i = a; bus.size_i = sz;
               bus.unsigned_i = uns; bus.st_data_i = d;
               model_access(we, a, sz, uns, d, x_err, x_ld);
            end else begin
               bus.req_i = 1'b0;
            end
         end else begin
            checks++;
            if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
               failures++;
               $display("FAIL b2b_idle_%0d got=%b/%b exp=0/1", c, bus.valid_o, bus.ready_o);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      run_op(1'b1, 12'h800, 2'd2, 1'b0, 32'hCAFEF00D);
      run_op(1'b1, 12'h8A0, 2'd2, 1'b0, 32'h00C0FFEE);
      checks++; if (g_out === '0) begin failures++; $display("FAIL rmid_setup got=%h exp=nonzero", g_out); end
      @(negedge clk);
      bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 12'h750; bus.size_i = 2'd2;
      @(posedge clk); #1;
      bus.req_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL rmid_no_valid got=%b exp=0", bus.valid_o); end
      @(posedge clk); #1;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || io_out !== '0) begin
         failures++;
         $display("FAIL rmid_state got=%b/%b/%h exp=0/1/0", bus.valid_o, bus.ready_o, io_out);
      end
      @(negedge clk);
      bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 12'h800; bus.size_i = 2'd2;
      bus.st_data_i = 32'hDEADBEEF;
      @(posedge clk); #1;
      checks++; if (io_out !== '0 || bus.valid_o !== 1'b0) begin failures++; $display("FAIL rmid_store_out got=%h exp=0", io_out); end
      @(negedge clk);
      bus.addr_i = 12'h750;
      @(posedge clk); #1;
      bus.req_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      run_op(1'b0, 12'h750, 2'd2, 1'b0, 32'h0);
      checks++;
      if (g_ld !== 32'h1357EFDF || g_ld !== e_ld || g_out !== '0) begin
         failures++;
         $display("FAIL rmid_dmem got=%h exp=1357efdf", g_ld);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      io_sw = '0;
      m_sw  = '0;
      bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.size_i = '0;
      bus.unsigned_i = 1'b0; bus.st_data_i = '0;
      test_reset();
      test_dmem();
      test_out_regs();
      test_half_out();
      test_switch();
      test_illegal();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lsu_pio.md
# lsu_pio

Parametrised load/store unit with a request/valid handshake, registered data memory, size-aware (byte/half/word) accesses with sign extension, and a configurable bank of memory-mapped output registers plus one switch input port. It sits between the core's memory stage and the board I/O. It is the multi-cycle, misalignment-checked successor to the single-cycle LSU.

## Interface
- DMEM_WORDS, 512 — data memory depth in 32-bit words; occupies byte addresses 0x000 .. 4*DMEM_WORDS-1, max 0x7FF.
- N_OUT, 11 — number of output registers; register k sits at 0x800 + 0x10*k, with k < 16. Default order: hex0..hex7, ledr, ledg, lcd.
- clk_i  in  1  — the single clock; all state updates on its rising edge.
- rst_ni  in  1  — reset, synchronous and active-low.
- req_i  in  1  — request; accepted on an edge where req_i & ready_o.
- we_i  in  1  — 1 = store, 0 = load.
- addr_i  in  12  — byte address.
- size_i  in  2  — 00 byte, 01 half, 10 word; 11 is illegal and flagged as an error.
- unsigned_i  in  1  — load zero-extends when 1, sign-extends when 0.
- st_data_i  in  32  — store data, right-aligned.
- io_sw_i  in  32  — switch input, mapped at 0x900.
- ready_o  out  1  — unit can accept a request.
- valid_o  out  1  — one-cycle completion pulse for a load or a store.
- err_o  out  1  — qualified by valid_o; the access was misaligned or used an illegal size.
- ld_data_o  out  32  — load result, qualified by valid_o.
- io_out_o  out  32*N_OUT  — output registers; register k drives bits [32k+31:32k].

## Operation
- FSM with two states:
  - IDLE: ready_o=1. An accepted request moves the FSM to RESP.
  - RESP: ready_o=0, valid_o=1. The FSM returns to IDLE on the next edge.
  - One request is outstanding at a time.
- Request latch: on accept, register addr, size, unsigned_i and we_i, and capture the io_sw value.
- Misalignment:
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]≠0 is misaligned.
  - size 11 is illegal.
  - A misaligned or illegal access raises err_o in RESP, writes nothing, and returns ld_data_o=0.
- Stores:
  - Byte enables are 0001, 0011 or 1111, shifted left by addr[1:0].
  - Data is st_data_i shifted left by 8*addr[1:0].
  - The write is applied on the accept edge, to either the dmem word or output register k.
  - Unmapped addresses and writes to 0x900 are dropped silently; valid_o still pulses with err_o=0.
  - ld_data_o=0 for all stores.
- Loads:
  - Read the selected 32-bit word: dmem (synchronous read), output register k (read-back), the captured switch value (0x900–0x903), or 0 if unmapped.
  - Shift the word right by 8*addr[1:0], then mask to the access size.
  - Sign- or zero-extend according to unsigned_i.
- Address decode: output register k matches when addr[11:4] == 0x80 + k, for any addr[3:0]. Addresses 0x800+0x10*N_OUT .. 0x8FF are unmapped.

## Timing
- Load and store latency: accept edge → valid_o high during the following cycle. Throughput is one access per 2 cycles.
- io_out_o updates at the accept edge of the store, so the new value is visible in the RESP cycle.
- Reset values: state IDLE, ready_o=1, valid_o=0, err_o=0, ld_data_o=0, all io_out_o=0.
  - dmem contents are not reset.
  - Requests are ignored while rst_ni=0.
- Reset mid-operation:
  - Reset during RESP returns the FSM to IDLE on that edge with no valid_o pulse.
  - A store presented on the same edge as reset is not performed; reset wins.
- req_i held high continuously: a new request is accepted on every IDLE cycle, giving alternating accept/valid cycles.

## Configuration
- LSU_SW_SYNC_EN defined: io_sw_i passes through a two-flop synchronizer (reset to 0) before capture. A switch change becomes loadable 2 cycles later.
- LSU_SW_SYNC_EN undefined: io_sw_i is captured directly at the accept edge.

## Structure
- lsu_pkg holds:
  - size encoding enum (SZ_B, SZ_H, SZ_W)
  - FSM state enum
  - address-map constants: DMEM_BASE 0x000, OUT_BASE 0x800, OUT_STRIDE 0x10, SW_ADDR 0x900
  - the byte-enable/extension helper functions
- One sub-module, lsu_dmem: single-port synchronous RAM, DMEM_WORDS x 32, with a per-byte write enable and a registered read.

## Test plan
- Reset, then store word 0x13579BDF at 0x752 → err_o=1, no write. Store the same word at 0x750, then load word from 0x750 → ld_data_o=0x13579BDF, valid_o exactly one cycle after accept.
- Store byte 0xEF at 0x751, then load byte from 0x751 (signed) → 0xFFFFFFEF. Load it unsigned → 0x000000EF. Load word from 0x750 → 0x1357EFDF.
- Store word 0x01234567 to 0x800 + 0x10*k for each k < N_OUT → only io_out_o slice k equals 0x01234567. Load from each address → 0x01234567.
- Store half 0xBEEF at 0x812 with io_out_o[1]=0x01234567 → io_out_o[1]=0xBEEF4567. Store half at 0x813 → err_o=1, register unchanged.
- io_sw_i=0x5, load word from 0x900 → 0x5 (with LSU_SW_SYNC_EN, only after 2 settle cycles). Load from 0x912 → 0. Store to 0x900 → no effect.
- Drop rst_ni during RESP after output registers have been written → no valid_o pulse, all io_out_o=0, ready_o=1. dmem at 0x750 still reads back 0x1357EFDF.
